// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential add/sub divider.
package divider_pkg;
  localparam int DIV_W = 36;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  // Iteration counter width; at least one bit even for tiny W.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/addsub_divider_if.sv
// Request/result handshake bundle for addsub_divider.
interface divider_if #(parameter int W = divider_pkg::DIV_W);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/addsub_w.sv
// N-bit two's complement adder/subtractor: y = a + b, or a - b when sub is set.
module addsub_w #(
  parameter int N = 37
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] y
);
  assign y = a + (sub ? ~b : b) + {{(N-1){1'b0}}, sub};
endmodule

// File: rtl/addsub_divider.sv
// Unsigned W-bit non-restoring divider, one quotient bit per clock, sharing a
// single W+1-bit add/sub between the iteration and final remainder correction.
module addsub_divider
  import divider_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic     clk,
  input  logic     reset_n,
  divider_if.slave bus
);
  localparam int CW = cnt_w(W);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [W:0]    r_p;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_d;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_rem;
  logic          r_dbz;

  logic [W:0]    w_p_sh;
  logic [W:0]    w_a;
  logic [W:0]    w_b;
  logic [W:0]    w_y;
  logic          w_sub;
  logic [W-1:0]  w_rem;

  // RUN feeds the shifted partial remainder; FIX adds D back to the unshifted P.
  assign w_p_sh = {r_p[W-1:0], r_q[W-1]};
  assign w_a    = (r_state == FIX) ? r_p : w_p_sh;
  assign w_b    = {1'b0, r_d};
  assign w_sub  = (r_state == RUN) & ~r_p[W];

  addsub_w #(.N(W+1)) u_addsub (
    .a   (w_a),
    .b   (w_b),
    .sub (w_sub),
    .y   (w_y)
  );

  assign w_rem = r_p[W] ? w_y[W-1:0] : r_p[W-1:0];

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = (r_state == DONE);
  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_d   <= bus.divisor;
          r_q   <= bus.dividend;
          r_p   <= '0;
          r_cnt <= '0;
          if (bus.divisor == '0) begin
            r_quo   <= '1;
            r_rem   <= bus.dividend;
            r_dbz   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= RUN;
          end
        end
        RUN: begin
          r_p   <= w_y;
          r_q   <= {r_q[W-2:0], ~w_y[W]};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(W-1)) r_state <= FIX;
        end
        FIX: begin
          r_p     <= r_p[W] ? w_y : r_p;
          r_quo   <= r_q;
          r_rem   <= w_rem;
          r_dbz   <= 1'b0;
          r_state <= DONE;
        end
        DONE: if (bus.out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_divider.sv
// Scoreboard bench for addsub_divider: reference results queued on accept, compared on result handshake.
module tb_addsub_divider;
  import divider_pkg::*;
  localparam int W = DIV_W;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  divider_if #(.W(W)) bus();

  addsub_divider #(.W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_push  = 0;
  int   n_res   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] r36();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[W-1:0];
  endfunction

  // Result side: pop on every handshake, plus the ready/valid exclusion rule.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("rdy_vld_excl", 64'(bus.in_ready & bus.out_valid), 64'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_nonempty", 64'(sbq.size()), 64'd1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("quotient",    64'(bus.quotient),    64'(e.q));
          chk("remainder",   64'(bus.remainder),   64'(e.r));
          chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
          n_res++;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    int t;
    t = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk); t++;
    end
    chk("accept", 64'(bus.in_ready), 64'd1);
    if (bus.in_ready && push) begin
      sbq.push_back(ref_div(a, b)); n_push++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is visible.
  task automatic wait_valid(output int k);
    k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 200) begin
      @(negedge clk); k++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 500) begin
      @(negedge clk); t++;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
  endtask

  task automatic gen(output logic [W-1:0] a, output logic [W-1:0] b);
    a = r36() >> $urandom_range(0, W-1);
    case ($urandom_range(0, 5))
      0: b = 36'd1;
      1: b = 36'h8_0000_0000;
      2: b = W'($urandom_range(1, 1000));
      3: b = r36();
      4: b = r36() >> $urandom_range(1, W-1);
      default: b = W'($urandom_range(0, 3));
    endcase
  endtask

  // Operands change every cycle while busy; only accepted ones are scored.
  task automatic stream(input int n);
    int sent, cyc;
    logic [W-1:0] a, b;
    sent = 0; cyc = 0;
    @(posedge clk); #1;
    gen(a, b);
    bus.in_valid = 1'b1; bus.dividend = a; bus.divisor = b;
    while (sent < n && cyc < n * (W + 8)) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sbq.push_back(ref_div(a, b)); n_push++; sent++;
      end
      @(posedge clk); #1;
      cyc++;
      gen(a, b);
      bus.dividend = a; bus.divisor = b;
    end
    bus.in_valid = 1'b0;
    chk("stream_sent", 64'(sent), 64'(n));
  endtask

  initial begin
    int k;
    bus.in_valid = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),    64'd1);
    chk("rst_out_valid", 64'(bus.out_valid),   64'd0);
    chk("rst_quotient",  64'(bus.quotient),    64'd0);
    chk("rst_remainder", 64'(bus.remainder),   64'd0);
    chk("rst_dbz",       64'(bus.div_by_zero), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    send(36'd100, 36'd7, 1'b1);
    wait_valid(k);
    chk("lat_100_7", 64'(k), 64'(W + 1));
    drain();

    send(36'hF_FFFF_FFFF, 36'd1, 1'b1);
    drain();
    send(36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 1'b1);
    drain();

    send(36'd5, 36'd0, 1'b1);
    wait_valid(k);
    chk("lat_div0", 64'(k), 64'd0);
    drain();

    // Result held under back-pressure.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(36'd3, 36'd10, 1'b1);
    wait_valid(k);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_quo",   64'(bus.quotient),  64'd0);
      chk("hold_rem",   64'(bus.remainder), 64'd3);
      chk("hold_rdy",   64'(bus.in_ready),  64'd0);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_rdy",   64'(bus.in_ready),  64'd1);
    chk("release_valid", 64'(bus.out_valid), 64'd0);
    drain();

    stream(1000);
    drain();

    // Abort mid-iteration with reset; the aborted request produces nothing.
    send(36'd1234567, 36'd89, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(bus.out_valid),   64'd0);
    chk("abort_in_ready",  64'(bus.in_ready),    64'd1);
    chk("abort_quotient",  64'(bus.quotient),    64'd0);
    chk("abort_remainder", 64'(bus.remainder),   64'd0);
    chk("abort_dbz",       64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send(36'd77, 36'd7, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    chk("result_count", 64'(n_res), 64'(n_push));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
